// File: rtl/echo_pkg.sv
// Shared FSM state type, datapath widths and mode encodings for echo_pipeline_ctrl.
package echo_pkg;

   localparam int DOUBLE_W     = 64;
   localparam int SAMPLE_CNT_W = 13;

   localparam logic MODE_ADAPT  = 1'b0;
   localparam logic MODE_CANCEL = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      CONV_P,
      CONV_W,
      LAG_P,
      LAG_W,
      PROC_P,
      PROC_W,
      OUT
   } state_t;

endpackage

// File: rtl/echo_pipeline_ctrl_pulse_gen.sv
// Shared stage handshake helper: times the PULSE_CYCLES-wide enable window
// and flags a rising edge of the currently selected stage ready.
module pulse_gen #(
   parameter int PULSE_CYCLES = 2
) (
   input  logic clk_operation,
   input  logic rst,
   input  logic run,
   input  logic rdy,
   output logic pulse_done,
   output logic rdy_rise
);

   localparam int            CW   = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(PULSE_CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          rdy_prev_q, rdy_prev_d;

   always_comb begin
      cnt_d      = '0;
      rdy_prev_d = rdy;
      if (run && (cnt_q != LAST)) cnt_d = cnt_q + 1'b1;
   end

   assign pulse_done = run && (cnt_q == LAST);
   // The previous level is tracked through the *_P window, so a ready already
   // high when waiting begins is not mistaken for completion.
   assign rdy_rise   = rdy && !rdy_prev_q;

   always_ff @(posedge clk_operation) begin
      if (rst) begin
         cnt_q      <= '0;
         rdy_prev_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         rdy_prev_q <= rdy_prev_d;
      end
   end

endmodule

// File: rtl/echo_pipeline_ctrl.sv
// Echo canceller frame sequencer: conv -> lag -> approx/cancel -> output per frame.
// Optional STAGE_TIMEOUT_EN aborts a frame when a stage never raises ready.
module echo_pipeline_ctrl
   import echo_pkg::*;
#(
   parameter int SAMPLING_CYCLE = 1510,
   parameter int MAX_ITERATION  = 64,
   parameter int PULSE_CYCLES   = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                    clk_operation,
   input  logic                    rst,
   input  logic [SAMPLE_CNT_W-1:0] sampling_cycle_counter,
   input  logic                    ready_conv,
   input  logic                    ready_lag,
   input  logic                    ready_approx,
   input  logic                    ready_cancel,
   input  logic [DOUBLE_W-1:0]     e,
   input  logic [DOUBLE_W-1:0]     signal_without_echo,
   output logic                    enable_conv,
   output logic                    enable_lag,
   output logic                    enable_approx,
   output logic                    enable_cancel,
   output logic                    enable_sampling,
   output logic                    enable_out,
   output logic [DOUBLE_W-1:0]     double_out,
   output logic                    mode,
   output logic [6:0]              iteration,
   output logic                    overrun,
   output logic                    timeout
);

   localparam logic [6:0] ITER_MAX = 7'(MAX_ITERATION);

   state_t              state_q, state_d;
   logic                zero_prev_q, zero_prev_d;
   logic                mode_q, mode_d;
   logic [6:0]          iter_q, iter_d;
   logic                ovr_q, ovr_d;
   logic                samp_q, samp_d;
   logic                eout_q, eout_d;
   logic [DOUBLE_W-1:0] dout_q, dout_d;
   logic [3:0]          en_q, en_d;
   logic                frame_start, in_pulse, in_wait, rdy_sel;
   logic                pulse_done, rdy_rise, to_hit;

   // Only the first cycle of a zero run counts, so a held counter starts one frame.
   assign frame_start = (sampling_cycle_counter == '0) && !zero_prev_q;
   assign in_pulse    = state_q inside {CONV_P, LAG_P, PROC_P};
   assign in_wait     = state_q inside {CONV_W, LAG_W, PROC_W};

   always_comb begin
      case (state_q)
         CONV_P, CONV_W: rdy_sel = ready_conv;
         LAG_P, LAG_W:   rdy_sel = ready_lag;
         PROC_P, PROC_W: rdy_sel = (mode_q == MODE_CANCEL) ? ready_cancel : ready_approx;
         default:        rdy_sel = 1'b0;
      endcase
   end

   pulse_gen #(.PULSE_CYCLES(PULSE_CYCLES)) u_pulse_gen (
      .clk_operation (clk_operation),
      .rst           (rst),
      .run           (in_pulse),
      .rdy           (rdy_sel),
      .pulse_done    (pulse_done),
      .rdy_rise      (rdy_rise)
   );

`ifdef STAGE_TIMEOUT_EN
   localparam int          TW      = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic          timeout_q, timeout_d;

   always_comb begin
      to_cnt_d  = '0;
      if (in_wait) to_cnt_d = to_cnt_q + 1'b1;
      timeout_d = timeout_q | (to_hit && !rdy_rise);
   end

   assign to_hit  = in_wait && (to_cnt_q == TO_LAST);
   assign timeout = timeout_q;

   always_ff @(posedge clk_operation) begin
      if (rst) begin
         to_cnt_q  <= '0;
         timeout_q <= 1'b0;
      end else begin
         to_cnt_q  <= to_cnt_d;
         timeout_q <= timeout_d;
      end
   end
`else
   logic [31:0] unused_cfg;
   assign unused_cfg = 32'(TIMEOUT_CYCLES);
   assign to_hit     = 1'b0;
   assign timeout    = 1'b0;
`endif

   logic [31:0] unused_frame_len;
   assign unused_frame_len = 32'(SAMPLING_CYCLE);

   always_comb begin
      state_d     = state_q;
      zero_prev_d = (sampling_cycle_counter == '0);
      mode_d      = mode_q;
      iter_d      = iter_q;
      ovr_d       = ovr_q | (frame_start && (state_q != IDLE));
      samp_d      = samp_q;
      eout_d      = 1'b0;
      dout_d      = dout_q;
      case (state_q)
         IDLE: if (frame_start) begin
            state_d = CONV_P;
            if (iter_q == ITER_MAX) mode_d = MODE_CANCEL;
         end
         CONV_P: if (pulse_done) state_d = CONV_W;
         CONV_W: if (rdy_rise)   state_d = LAG_P;
         LAG_P:  if (pulse_done) state_d = LAG_W;
         LAG_W:  if (rdy_rise) begin
            state_d = PROC_P;
            samp_d  = 1'b1;
         end
         PROC_P: if (pulse_done) state_d = PROC_W;
         PROC_W: if (rdy_rise)   state_d = OUT;
         OUT: begin
            state_d = IDLE;
            eout_d  = 1'b1;
            dout_d  = (mode_q == MODE_CANCEL) ? signal_without_echo : e;
            if ((mode_q == MODE_ADAPT) && (iter_q != ITER_MAX)) iter_d = iter_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
      if (in_wait && !rdy_rise && to_hit) state_d = IDLE;

      // Enables follow the next state so each one is a clean registered pulse.
      en_d[0] = (state_d == CONV_P);
      en_d[1] = (state_d == LAG_P);
      en_d[2] = (state_d == PROC_P) && (mode_d == MODE_ADAPT);
      en_d[3] = (state_d == PROC_P) && (mode_d == MODE_CANCEL);
   end

   always_ff @(posedge clk_operation) begin
      if (rst) begin
         state_q     <= IDLE;
         zero_prev_q <= 1'b0;
         mode_q      <= MODE_ADAPT;
         iter_q      <= '0;
         ovr_q       <= 1'b0;
         samp_q      <= 1'b1;
         eout_q      <= 1'b0;
         dout_q      <= '0;
         en_q        <= '0;
      end else begin
         state_q     <= state_d;
         zero_prev_q <= zero_prev_d;
         mode_q      <= mode_d;
         iter_q      <= iter_d;
         ovr_q       <= ovr_d;
         samp_q      <= samp_d;
         eout_q      <= eout_d;
         dout_q      <= dout_d;
         en_q        <= en_d;
      end
   end

   assign enable_conv     = en_q[0];
   assign enable_lag      = en_q[1];
   assign enable_approx   = en_q[2];
   assign enable_cancel   = en_q[3];
   assign enable_sampling = samp_q;
   assign enable_out      = eout_q;
   assign double_out      = dout_q;
   assign mode            = mode_q;
   assign iteration       = iter_q;
   assign overrun         = ovr_q;

endmodule

// File: tb/tb_echo_pipeline_ctrl.sv
// Randomized bench for echo_pipeline_ctrl against a frame-level reference model.
// Covers STAGE_TIMEOUT_EN builds as well as the default build.
module tb_echo_pipeline_ctrl;

   localparam int SAMPLING_CYCLE = 1510;
   localparam int MAX_ITERATION  = 64;
   localparam int PULSE_CYCLES   = 2;
   localparam int TIMEOUT_CYCLES = 1024;

   logic        clk = 1'b0;
   logic        rst;
   logic [12:0] sampling_cycle_counter;
   logic        ready_conv, ready_lag, ready_approx, ready_cancel;
   logic [63:0] e, signal_without_echo;
   logic        enable_conv, enable_lag, enable_approx, enable_cancel;
   logic        enable_sampling, enable_out, mode, overrun, timeout;
   logic [63:0] double_out;
   logic [6:0]  iteration;

   always #5 clk = ~clk;

   echo_pipeline_ctrl #(
      .SAMPLING_CYCLE(SAMPLING_CYCLE), .MAX_ITERATION(MAX_ITERATION),
      .PULSE_CYCLES(PULSE_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .clk_operation(clk), .rst(rst), .sampling_cycle_counter(sampling_cycle_counter),
      .ready_conv(ready_conv), .ready_lag(ready_lag), .ready_approx(ready_approx),
      .ready_cancel(ready_cancel), .e(e), .signal_without_echo(signal_without_echo),
      .enable_conv(enable_conv), .enable_lag(enable_lag), .enable_approx(enable_approx),
      .enable_cancel(enable_cancel), .enable_sampling(enable_sampling),
      .enable_out(enable_out), .double_out(double_out), .mode(mode),
      .iteration(iteration), .overrun(overrun), .timeout(timeout)
   );

   int n_chk = 0, n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Bus monitor: pulse counts, widths and exclusivity of stage enables.
   int n_out = 0, n_multi = 0, n_badw = 0;
   int n_rise[4], n_fall[4], run_len[4];
   initial for (int s = 0; s < 4; s++) begin n_rise[s] = 0; n_fall[s] = 0; run_len[s] = 0; end

   always begin
      logic [3:0] en;
      @(posedge clk); #2;
      en = {enable_cancel, enable_approx, enable_lag, enable_conv};
      if ($countones(en) > 1) n_multi++;
      for (int s = 0; s < 4; s++) begin
         if (en[s]) begin
            if (run_len[s] == 0) n_rise[s]++;
            run_len[s]++;
         end else if (run_len[s] != 0) begin
            if (run_len[s] != PULSE_CYCLES) n_badw++;
            n_fall[s]++;
            run_len[s] = 0;
         end
      end
      if (enable_out) n_out++;
   end

   // Reference model state
   int          exp_iter = 0;
   logic        exp_mode = 0, exp_ovr = 0, exp_to = 0;
   logic [63:0] cur_ev, cur_sv;
   int          fb_out;
   int          fb_rise[4], fb_fall[4];

   task automatic step(); @(negedge clk); endtask

   function automatic logic [63:0] rnd64(); return {$urandom, $urandom}; endfunction
   function automatic logic [12:0] nz(); return 13'($urandom_range(1, SAMPLING_CYCLE - 1)); endfunction
   function automatic int proc_s(); return exp_mode ? 3 : 2; endfunction

   task automatic set_rdy(input int s, input logic v);
      case (s)
         0: ready_conv = v;
         1: ready_lag = v;
         2: ready_approx = v;
         default: ready_cancel = v;
      endcase
   endtask

   task automatic start_frame(input logic [63:0] ev, input logic [63:0] sv);
      cur_ev = ev; cur_sv = sv;
      e = ev; signal_without_echo = sv;
      fb_out = n_out;
      for (int s = 0; s < 4; s++) begin fb_rise[s] = n_rise[s]; fb_fall[s] = n_fall[s]; end
      if (exp_iter == MAX_ITERATION) exp_mode = 1;
      sampling_cycle_counter = '0;
      repeat ($urandom_range(1, 4)) step();
      sampling_cycle_counter = nz();
   endtask

   task automatic wait_fall(input int s, input string tag);
      int t = 0;
      while (n_fall[s] == fb_fall[s] && t < 400) begin step(); t++; end
      chk(tag, 64'(n_fall[s] > fb_fall[s]), 1);
   endtask

   task automatic do_stage(input int s, input int dly);
      wait_fall(s, "stage_enable_seen");
      repeat (dly) step();
      set_rdy(s, 1'b1);
      step();
      set_rdy(s, 1'b0);
   endtask

   task automatic finish_frame();
      int t = 0;
      while (n_out == fb_out && t < 200) begin step(); t++; end
      if (!exp_mode && exp_iter < MAX_ITERATION) exp_iter++;
      repeat (3) step();
      chk("out_once", 64'(n_out - fb_out), 1);
      chk("one_start", 64'(n_rise[0] - fb_rise[0]), 1);
      chk("double_out", double_out, exp_mode ? cur_sv : cur_ev);
      chk("iteration", 64'(iteration), 64'(exp_iter));
      chk("mode", 64'(mode), 64'(exp_mode));
      chk("overrun", 64'(overrun), 64'(exp_ovr));
      chk("timeout", 64'(timeout), 64'(exp_to));
      chk("other_proc_silent", 64'(n_rise[exp_mode ? 2 : 3] - fb_rise[exp_mode ? 2 : 3]), 0);
      chk("enable_sampling", 64'(enable_sampling), 1);
   endtask

   task automatic full_frame();
      start_frame(rnd64(), rnd64());
      do_stage(0, $urandom_range(0, 6));
      do_stage(1, $urandom_range(0, 6));
      do_stage(proc_s(), $urandom_range(0, 6));
      finish_frame();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt, guard;
      rst = 1'b1; sampling_cycle_counter = 13'd5;
      ready_conv = 0; ready_lag = 0; ready_approx = 0; ready_cancel = 0;
      e = '0; signal_without_echo = '0;
      repeat (3) step();
      chk("rst_enables", 64'({enable_conv, enable_lag, enable_approx, enable_cancel, enable_out}), 0);
      chk("rst_sampling", 64'(enable_sampling), 1);
      chk("rst_double_out", double_out, 0);
      chk("rst_state", 64'({mode, iteration, overrun, timeout}), 0);
      rst = 1'b0;
      repeat (2) step();

      // Reference frame: every ready rises 10 clocks after its enable.
      start_frame(64'h3FD0000000000000, rnd64());
      do_stage(0, 10 - PULSE_CYCLES);
      do_stage(1, 10 - PULSE_CYCLES);
      do_stage(2, 10 - PULSE_CYCLES);
      finish_frame();

      // Stage that never answers
      start_frame(rnd64(), rnd64());
      wait_fall(0, "to_conv_wait");
      cnt = 0;
`ifdef STAGE_TIMEOUT_EN
      while (!timeout && cnt < 2000) begin cnt++; step(); end
      exp_to = 1;
      chk("timeout_clock", 64'(cnt), 64'(TIMEOUT_CYCLES));
      repeat (3) step();
      chk("timeout_flag", 64'(timeout), 1);
      chk("timeout_iter", 64'(iteration), 64'(exp_iter));
      chk("timeout_no_out", 64'(n_out - fb_out), 0);
      chk("timeout_no_lag", 64'(n_rise[1] - fb_rise[1]), 0);
`else
      repeat (1100) step();
      chk("timeout_tied", 64'(timeout), 0);
      chk("wait_forever_no_lag", 64'(n_rise[1] - fb_rise[1]), 0);
      do_stage(0, 0);
      do_stage(1, 2);
      do_stage(proc_s(), 2);
      finish_frame();
`endif

      repeat (3) full_frame();

      // Stale ready_lag must not complete the lag stage.
      start_frame(rnd64(), rnd64());
      wait_fall(0, "stale_conv_wait");
      set_rdy(1, 1'b1);
      repeat (3) step();
      set_rdy(0, 1'b1); step(); set_rdy(0, 1'b0);
      wait_fall(1, "stale_lag_wait");
      repeat (20) step();
      chk("stale_lag_hold", 64'(n_rise[2] - fb_rise[2]), 0);
      set_rdy(1, 1'b0); step(); set_rdy(1, 1'b1); step(); set_rdy(1, 1'b0);
      do_stage(proc_s(), 3);
      finish_frame();

      // Frame start arriving mid-frame is dropped and flagged.
      start_frame(rnd64(), rnd64());
      do_stage(0, 2);
      do_stage(1, 2);
      wait_fall(proc_s(), "ovr_proc_wait");
      sampling_cycle_counter = '0;
      repeat (2) step();
      sampling_cycle_counter = nz();
      exp_ovr = 1;
      repeat (4) step();
      set_rdy(proc_s(), 1'b1); step(); set_rdy(proc_s(), 1'b0);
      finish_frame();
      repeat (20) step();
      chk("ovr_dropped", 64'(n_rise[0] - fb_rise[0]), 1);
      chk("ovr_single_out", 64'(n_out - fb_out), 1);

      // Reset during LAG_W aborts the frame.
      start_frame(rnd64(), rnd64());
      do_stage(0, 3);
      wait_fall(1, "rst_lag_wait");
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst_enables", 64'({enable_conv, enable_lag, enable_approx, enable_cancel, enable_out}), 0);
      chk("midrst_state", 64'({mode, iteration, overrun, timeout}), 0);
      chk("midrst_double_out", double_out, 0);
      chk("midrst_sampling", 64'(enable_sampling), 1);
      exp_iter = 0; exp_mode = 0; exp_ovr = 0; exp_to = 0;
      repeat (5) step();
      chk("midrst_no_out", 64'(n_out - fb_out), 0);
      full_frame();

      // Adapt until saturation, then the next frame switches to cancellation.
      guard = 0;
      while (exp_iter < MAX_ITERATION && guard < 100) begin full_frame(); guard++; end
      chk("adapt_saturated", 64'(iteration), 64'(MAX_ITERATION));
      chk("still_adapt", 64'(mode), 0);
      full_frame();
      chk("cancel_mode", 64'(mode), 1);
      chk("cancel_pulsed", 64'(n_rise[3] - fb_rise[3]), 1);
      full_frame();

      chk("enable_onehot", 64'(n_multi), 0);
      chk("pulse_width", 64'(n_badw), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
